signal_debouncer: RTL and testbench
===================================

// Module: signal_debouncer
// PURPOSE
//  Cleans a raw asynchronous level (push-button, contact, sensor line) before edge counting.
//  Synchronises the input, then qualifies every level change over a programmable stable window.
//  Outputs a glitch-free level plus single-cycle rise/fall strobes.
//  Sits directly upstream of the falling-edge event counter and drives its signal_in.
// PARAMETERS
//  STABLE_CYCLES  16  consecutive synchronised samples required to accept a new level (>=2)
//  SYNC_STAGES    2   synchroniser flop depth (>=2)
//  CNT_W          $clog2(STABLE_CYCLES+1)  localparam, stability counter width
// PORTS
//  clk           in   1  single system clock, all logic on posedge
//  rst           in   1  synchronous reset, active-high
//  signal_in     in   1  raw asynchronous input
//  signal_out    out  1  debounced level
//  rise_pulse    out  1  1-cycle strobe, accepted 0->1 change
//  fall_pulse    out  1  1-cycle strobe, accepted 1->0 change
//  glitch_count  out  8  rejected-transition count (only with DEBOUNCE_GLITCH_CNT_EN)
// BEHAVIOUR
//  - Reset: one clock, synchronous, rst=1 on a posedge. Synchroniser flops=0, cnt=0, state=S_LOW.
//    Outputs after reset: signal_out=0, rise_pulse=0, fall_pulse=0, glitch_count=0.
//  - Reset mid-check or mid-pulse aborts with no strobe. rst has priority over all other logic.
//  - sync_q = last synchroniser stage. The FSM only ever looks at sync_q, never signal_in.
//  - FSM states (typedef in package): S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK.
//    S_LOW:      sync_q=1 -> S_RISE_CHK, cnt=1; else stay.
//    S_RISE_CHK: sync_q=0 -> S_LOW, cnt=0, glitch event.
//                sync_q=1 and cnt==STABLE_CYCLES-1 -> S_HIGH, cnt=0, signal_out=1, rise_pulse=1.
//                otherwise cnt++.
//    S_HIGH / S_FALL_CHK: mirror of S_LOW / S_RISE_CHK with polarity inverted; accept gives fall_pulse.
//  - signal_out, rise_pulse and fall_pulse are registered.
//    Each strobe is high exactly one cycle, coincident with the signal_out change.
//    rise_pulse and fall_pulse are never high together.
//  - Latency: edge k is the first posedge sampling a new stable input.
//    signal_out changes at edge k+SYNC_STAGES+STABLE_CYCLES-1 (defaults: k+17).
//  - Any contrary sample inside a CHK state restarts qualification from zero. No partial credit.
//  - Input held high through reset release: normal qualification runs, rise_pulse fires once.
//  - cnt never exceeds STABLE_CYCLES-1. No wrap-around is possible.
// CONFIGURATION
//  - `DEBOUNCE_GLITCH_CNT_EN defined:
//    glitch_count port exists. It increments by 1 on each CHK->abort transition.
//    It saturates at 8'hFF and is cleared only by rst.
//  - Not defined: port and counter are absent. Core behaviour and latency are identical.
// STRUCTURE
//  - debounce_pkg: state_t enum (S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK).
//    Also DEF_STABLE_CYCLES=16, DEF_SYNC_STAGES=2, GLITCH_MAX=8'hFF.
//  - Sub-module sync_chain #(SYNC_STAGES): reset-to-0 flop chain, signal_in -> sync_q.
//  - Top holds the FSM, the stability counter and the optional glitch counter.
//    Static parameter checks: STABLE_CYCLES>=2, SYNC_STAGES>=2.
// TESTING  (bench uses STABLE_CYCLES=4, SYNC_STAGES=2 unless noted)
//  1. rst=1 for 3 cycles with signal_in=1 -> all outputs 0.
//     After release: signal_out=1 at edge 5, rise_pulse high that cycle only.
//  2. Clean step 0->1 first sampled at edge 10 -> signal_out=1 at edge 15, one rise_pulse.
//     Then 1->0 at edge 30 -> signal_out=0 at edge 35, one fall_pulse.
//  3. Bounce: 1 for 2 cycles, 0 for 1, 1 for 3, 0 for 2, then steady 1.
//     -> No output change until 4 consecutive synced 1s; exactly one rise_pulse.
//     -> glitch_count=2 with macro.
//  4. Single-cycle 1 spikes every 3 cycles for 100 cycles -> signal_out stays 0, no strobes.
//     -> glitch_count saturates correctly with macro (repeat 300 spikes -> 8'hFF).
//  5. rst asserted in S_RISE_CHK with cnt=2 -> next cycle state S_LOW, outputs 0, no pulse.
//  6. Defaults (16/2), 50 random accepted toggles -> every signal_out change lags input by 17 edges.
//     -> Pulse count equals toggle count; a downstream falling-edge counter matches fall_pulse count.

Source files
------------

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for signal_debouncer.
//   state_t            : debounce FSM states
//   DEF_STABLE_CYCLES  : default qualification window (synchronised samples)
//   DEF_SYNC_STAGES    : default synchroniser depth
//   GLITCH_MAX         : saturation value of the rejected-transition counter
//   glitch_sat_inc()   : saturating +1 used by the optional glitch counter
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW,
    S_RISE_CHK,
    S_HIGH,
    S_FALL_CHK
  } state_t;

  localparam int unsigned DEF_STABLE_CYCLES = 16;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam logic [7:0]  GLITCH_MAX        = 8'hFF;

  function automatic logic [7:0] glitch_sat_inc(input logic [7:0] value);
    return (value == GLITCH_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
// Reset-to-0 flop chain bringing an asynchronous level into the clk domain.
// Ports:
//   clk        : system clock, posedge
//   rst        : synchronous reset, active-high
//   signal_in  : raw asynchronous input
//   sync_q     : output of the last synchroniser stage
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic signal_in,
  output logic sync_q
);

  logic [STAGES-1:0] stage;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], signal_in};
    end
  end

  assign sync_q = stage[STAGES-1];

endmodule

// File: rtl/signal_debouncer.sv
// -----------------------------------------------------------------------------
// signal_debouncer
// Synchronises a raw level, then accepts a level change only after
// STABLE_CYCLES consecutive identical synchronised samples. Produces a clean
// level plus single-cycle rise/fall strobes coincident with the level change.
// Latency: first edge sampling a new stable level = k; signal_out changes at
// edge k + SYNC_STAGES + STABLE_CYCLES - 1.
// Ports:
//   clk           : system clock, posedge
//   rst           : synchronous reset, active-high, highest priority
//   signal_in     : raw asynchronous input
//   signal_out    : debounced level (registered)
//   rise_pulse    : 1-cycle strobe on an accepted 0->1 change
//   fall_pulse    : 1-cycle strobe on an accepted 1->0 change
//   glitch_count  : saturating count of aborted qualifications
//                   (present only when DEBOUNCE_GLITCH_CNT_EN is defined)
// Build option: DEBOUNCE_GLITCH_CNT_EN
// -----------------------------------------------------------------------------
module signal_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       signal_in,
  output logic       signal_out,
  output logic       rise_pulse,
  output logic       fall_pulse
`ifdef DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_count
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("signal_debouncer: STABLE_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("signal_debouncer: SYNC_STAGES must be >= 2");
  end

  logic             sync_q;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .signal_in(signal_in),
    .sync_q   (sync_q)
  );

  // Entering a CHK state already counts the first new sample (cnt=1), so the
  // accept fires on the STABLE_CYCLES-th consecutive sample. Any contrary
  // sample drops straight back with cnt cleared: no partial credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_LOW;
      cnt          <= '0;
      signal_out   <= 1'b0;
      rise_pulse   <= 1'b0;
      fall_pulse   <= 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
      glitch_count <= '0;
`endif
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      unique case (state)
        S_LOW: begin
          if (sync_q) begin
            state <= S_RISE_CHK;
            cnt   <= CNT_ONE;
          end
        end
        S_RISE_CHK: begin
          if (!sync_q) begin
            state <= S_LOW;
            cnt   <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_count <= glitch_sat_inc(glitch_count);
`endif
          end else if (cnt == CNT_LAST) begin
            state      <= S_HIGH;
            cnt        <= '0;
            signal_out <= 1'b1;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!sync_q) begin
            state <= S_FALL_CHK;
            cnt   <= CNT_ONE;
          end
        end
        S_FALL_CHK: begin
          if (sync_q) begin
            state <= S_HIGH;
            cnt   <= '0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
            glitch_count <= glitch_sat_inc(glitch_count);
`endif
          end else if (cnt == CNT_LAST) begin
            state      <= S_LOW;
            cnt        <= '0;
            signal_out <= 1'b0;
            fall_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= S_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signal_debouncer.sv
// -----------------------------------------------------------------------------
// tb_signal_debouncer
// Directed bench for signal_debouncer. dut_a uses STABLE_CYCLES=4 (latency 5
// edges), dut_b uses the defaults 16/2 (latency 17 edges). Inputs change on
// negedge; outputs are sampled 1 time unit after posedge.
// Lag convention: edge j=1 is the first posedge sampling the new input (edge k),
// so a change seen after edge j has lag j-1.
// -----------------------------------------------------------------------------
module tb_signal_debouncer;
  import debounce_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, in_a = 1'b0, out_a, rise_a, fall_a;
  logic rst_b = 1'b1, in_b = 1'b0, out_b, rise_b, fall_b;
`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gc_a, gc_b;
`endif

  signal_debouncer #(.STABLE_CYCLES(4), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst_a), .signal_in(in_a), .signal_out(out_a),
    .rise_pulse(rise_a), .fall_pulse(fall_a)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc_a)
`endif
  );

  signal_debouncer dut_b (
    .clk(clk), .rst(rst_b), .signal_in(in_b), .signal_out(out_b),
    .rise_pulse(rise_b), .fall_pulse(fall_b)
`ifdef DEBOUNCE_GLITCH_CNT_EN
    , .glitch_count(gc_b)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Pulse monitors and a downstream falling-edge counter on dut_b's level.
  int rise_cnt_a = 0, fall_cnt_a = 0, both_a = 0;
  int rise_cnt_b = 0, fall_cnt_b = 0, both_b = 0, down_falls_b = 0;
  logic prev_out_b = 1'b0;
  always @(posedge clk) begin
    if (rise_a) rise_cnt_a++;
    if (fall_a) fall_cnt_a++;
    if (rise_a && fall_a) both_a++;
    if (rise_b) rise_cnt_b++;
    if (fall_b) fall_cnt_b++;
    if (rise_b && fall_b) both_b++;
    if (prev_out_b && !out_b) down_falls_b++;
    prev_out_b = out_b;
  end

  task automatic edge_a();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for out_a to reach lvl; lag = edges after edge k, -1 on timeout.
  task automatic lag_a(input logic lvl, input int bound, output int lag);
    lag = -1;
    for (int j = 1; j <= bound; j++) begin
      edge_a();
      if (out_a === lvl) begin
        lag = j - 1;
        return;
      end
    end
  endtask

  task automatic reset_a();
    @(negedge clk); rst_a = 1'b1; in_a = 1'b0;
    @(negedge clk); rst_a = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  int lag, r0, f0;

  initial begin
    // ---- 1: reset with input high, then qualification after release ----
    @(negedge clk); rst_a = 1'b1; in_a = 1'b1;
    repeat (3) edge_a();
    check("t1_rst_out", out_a, 0);
    check("t1_rst_rise", rise_a, 0);
    check("t1_rst_fall", fall_a, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("t1_rst_gc", gc_a, 0);
`endif
    @(negedge clk); rst_a = 1'b0; r0 = rise_cnt_a;
    lag_a(1'b1, 30, lag);
    check("t1_lag", lag, 5);
    check("t1_rise_on", rise_a, 1);
    edge_a();
    check("t1_rise_off", rise_a, 0);
    check("t1_out_hold", out_a, 1);
    check("t1_rise_cnt", rise_cnt_a - r0, 1);

    // ---- 2: clean steps both ways ----
    reset_a();
    r0 = rise_cnt_a; f0 = fall_cnt_a;
    @(negedge clk); in_a = 1'b1;
    lag_a(1'b1, 30, lag);
    check("t2_rise_lag", lag, 5);
    check("t2_rise_pulse", rise_a, 1);
    repeat (10) @(negedge clk);
    in_a = 1'b0;
    lag_a(1'b0, 30, lag);
    check("t2_fall_lag", lag, 5);
    check("t2_fall_pulse", fall_a, 1);
    edge_a();
    check("t2_fall_off", fall_a, 0);
    check("t2_rise_cnt", rise_cnt_a - r0, 1);
    check("t2_fall_cnt", fall_cnt_a - f0, 1);

    // ---- 3: bounce 1,1,0,1,1,1,0,0 then steady 1 ----
    reset_a();
    r0 = rise_cnt_a;
    begin
      logic [7:0] pat;
      pat = 8'b1101_1100;  // applied MSB first
      for (int i = 7; i >= 0; i--) begin
        @(negedge clk); in_a = pat[i];
        edge_a();
        check("t3_bounce_out", out_a, 0);
      end
    end
    @(negedge clk); in_a = 1'b1;
    lag_a(1'b1, 30, lag);
    check("t3_lag", lag, 5);
    edge_a();
    check("t3_rise_cnt", rise_cnt_a - r0, 1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("t3_glitch", gc_a, 2);
`endif

    // ---- 4: single-cycle spikes every 3 cycles ----
    reset_a();
    r0 = rise_cnt_a; f0 = fall_cnt_a;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk); in_a = 1'b1;
      @(negedge clk); in_a = 1'b0;
      @(negedge clk);
    end
    repeat (6) edge_a();
    check("t4_out", out_a, 0);
    check("t4_rise_cnt", rise_cnt_a - r0, 0);
    check("t4_fall_cnt", fall_cnt_a - f0, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("t4_glitch34", gc_a, 34);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); in_a = 1'b1;
      @(negedge clk); in_a = 1'b0;
      @(negedge clk);
    end
    repeat (6) edge_a();
    check("t4_glitch_sat", gc_a, 8'hFF);
`endif

    // ---- 5: reset in S_RISE_CHK with cnt=2 ----
    reset_a();
    r0 = rise_cnt_a;
    @(negedge clk); in_a = 1'b1;
    repeat (4) edge_a();
    check("t5_pre_state", 32'(dut_a.state), 32'(S_RISE_CHK));
    check("t5_pre_cnt", 32'(dut_a.cnt), 2);
    @(negedge clk); rst_a = 1'b1;
    edge_a();
    check("t5_state", 32'(dut_a.state), 32'(S_LOW));
    check("t5_cnt", 32'(dut_a.cnt), 0);
    check("t5_out", out_a, 0);
    check("t5_rise", rise_a, 0);
    check("t5_rise_cnt", rise_cnt_a - r0, 0);
    @(negedge clk); rst_a = 1'b0; in_a = 1'b0;
    check("t_both_a", both_a, 0);

    // ---- 6: defaults, 50 accepted toggles ----
    @(negedge clk); rst_b = 1'b1; in_b = 1'b0;
    @(negedge clk); rst_b = 1'b0;
    repeat (20) @(negedge clk);
    r0 = rise_cnt_b; f0 = fall_cnt_b;
    for (int t = 0; t < 50; t++) begin
      int hold;
      hold = $urandom_range(40, 20);
      @(negedge clk); in_b = ~in_b;
      lag = -1;
      for (int j = 1; j <= hold; j++) begin
        @(posedge clk); #1;
        if (lag < 0 && out_b === in_b) lag = j - 1;
      end
      check("t6_lag", lag, 17);
    end
    repeat (3) @(posedge clk);
    #1;
    check("t6_rise_cnt", rise_cnt_b - r0, 25);
    check("t6_fall_cnt", fall_cnt_b - f0, 25);
    check("t6_downstream", down_falls_b, fall_cnt_b - f0);
    check("t6_both", both_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
